// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for a shared, externally pipelined barrel shifter.
// Carries tag/port sideband alongside the shifter pipe and holds each result in an output register.
module shift_arbiter #(
  parameter int WIDTH     = 32,
  parameter int WIDTHDIST = 5,
  parameter int PIPELINE  = 2,
  parameter int TAGW      = 4
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 flush,

  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_data,
  input  logic [WIDTHDIST-1:0] req0_distance,
  input  logic                 req0_direction,
  input  logic [TAGW-1:0]      req0_tag,

  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_data,
  input  logic [WIDTHDIST-1:0] req1_distance,
  input  logic                 req1_direction,
  input  logic [TAGW-1:0]      req1_tag,

  output logic                 sh_aclr,
  output logic                 sh_clken,
  output logic [WIDTH-1:0]     sh_data,
  output logic [WIDTHDIST-1:0] sh_distance,
  output logic                 sh_direction,
  input  logic [WIDTH-1:0]     sh_result,

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [TAGW-1:0]      out_tag,
  output logic                 out_port,
  output logic                 busy
);

  logic            ptr_q, ptr_d;
  logic            grant_valid;
  logic            grant_port;
  logic            issue;
  logic [TAGW-1:0] issue_tag;

  logic            pe_valid;
  logic            pe_port;
  logic [TAGW-1:0] pe_tag;
  logic            sb_any;

  logic             out_valid_q, out_valid_d;
  logic             load;
  logic [WIDTH-1:0] out_result_q;
  logic [TAGW-1:0]  out_tag_q;
  logic             out_port_q;

  assign sh_aclr  = ~aclr_n;
  assign sh_clken = ~out_valid_q | out_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_port  = ptr_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_port  = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_port  = 1'b1;
    end
  end

  // aclr_n in the issue term keeps both readys low while reset is held
  assign issue      = grant_valid & sh_clken & ~flush & aclr_n;
  assign req0_ready = issue & ~grant_port;
  assign req1_ready = issue &  grant_port;

  assign sh_data      = grant_port ? req1_data      : req0_data;
  assign sh_distance  = grant_port ? req1_distance  : req0_distance;
  assign sh_direction = grant_port ? req1_direction : req0_direction;
  assign issue_tag    = grant_port ? req1_tag       : req0_tag;

  assign ptr_d = issue ? ~grant_port : ptr_q;

  generate
    if (PIPELINE == 0) begin : g_nopipe
      assign pe_valid = issue;
      assign pe_tag   = issue_tag;
      assign pe_port  = grant_port;
      assign sb_any   = 1'b0;
    end else begin : g_pipe
      logic [PIPELINE-1:0] sb_valid_q;
      logic [PIPELINE-1:0] sb_port_q;
      logic [TAGW-1:0]     sb_tag_q [PIPELINE];

      always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
          sb_valid_q <= '0;
          sb_port_q  <= '0;
          for (int i = 0; i < PIPELINE; i++) sb_tag_q[i] <= '0;
        end else begin
          if (sh_clken) begin
            sb_valid_q[0] <= issue;
            sb_port_q[0]  <= grant_port;
            sb_tag_q[0]   <= issue_tag;
            for (int i = 1; i < PIPELINE; i++) begin
              sb_valid_q[i] <= sb_valid_q[i-1];
              sb_port_q[i]  <= sb_port_q[i-1];
              sb_tag_q[i]   <= sb_tag_q[i-1];
            end
          end
          // results still inside the shifter are dropped by killing their valids
          if (flush) sb_valid_q <= '0;
        end
      end

      assign pe_valid = sb_valid_q[PIPELINE-1];
      assign pe_tag   = sb_tag_q[PIPELINE-1];
      assign pe_port  = sb_port_q[PIPELINE-1];
      assign sb_any   = |sb_valid_q;
    end
  endgenerate

  assign load = pe_valid & sh_clken & ~flush;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (load)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      ptr_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_port_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      if (load) begin
        out_result_q <= sh_result;
        out_tag_q    <= pe_tag;
        out_port_q   <= pe_port;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_port   = out_port_q;
  assign busy       = sb_any | out_valid_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: PIPELINE=2 instance with a modelled two-stage shifter,
// plus a PIPELINE=0 instance with a combinational shifter for the zero-latency case.
module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        flush;
  logic        out_ready;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_distance, req1_distance;
  logic        req0_direction, req1_direction;
  logic [3:0]  req0_tag, req1_tag;

  logic        req0_ready, req1_ready, sh_aclr, sh_clken, sh_direction;
  logic [31:0] sh_data, sh_result, out_result;
  logic [4:0]  sh_distance;
  logic        out_valid, out_port, busy;
  logic [3:0]  out_tag;

  logic        z_req0_ready, z_req1_ready, z_sh_aclr, z_sh_clken, z_sh_direction;
  logic [31:0] z_sh_data, z_sh_result, z_out_result;
  logic [4:0]  z_sh_distance;
  logic        z_out_valid, z_out_port, z_busy;
  logic [3:0]  z_out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  shift_arbiter #(.WIDTH(32), .WIDTHDIST(5), .PIPELINE(2), .TAGW(4)) dut2 (
    .clock(clock), .aclr_n(aclr_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_distance(req0_distance), .req0_direction(req0_direction), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_distance(req1_distance), .req1_direction(req1_direction), .req1_tag(req1_tag),
    .sh_aclr(sh_aclr), .sh_clken(sh_clken), .sh_data(sh_data), .sh_distance(sh_distance),
    .sh_direction(sh_direction), .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_port(out_port), .busy(busy)
  );

  shift_arbiter #(.WIDTH(32), .WIDTHDIST(5), .PIPELINE(0), .TAGW(4)) dut0 (
    .clock(clock), .aclr_n(aclr_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(z_req0_ready), .req0_data(req0_data),
    .req0_distance(req0_distance), .req0_direction(req0_direction), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(z_req1_ready), .req1_data(req1_data),
    .req1_distance(req1_distance), .req1_direction(req1_direction), .req1_tag(req1_tag),
    .sh_aclr(z_sh_aclr), .sh_clken(z_sh_clken), .sh_data(z_sh_data), .sh_distance(z_sh_distance),
    .sh_direction(z_sh_direction), .sh_result(z_sh_result),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_result(z_out_result),
    .out_tag(z_out_tag), .out_port(z_out_port), .busy(z_busy)
  );

  function automatic logic [31:0] shf(input logic [31:0] d, input logic [4:0] s, input logic r);
    return r ? (d >> s) : (d << s);
  endfunction

  // external shifter models
  logic [31:0] s1_q, s2_q;
  always @(posedge clock or posedge sh_aclr) begin
    if (sh_aclr) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (sh_clken) begin
      s1_q <= shf(sh_data, sh_distance, sh_direction);
      s2_q <= s1_q;
    end
  end
  assign sh_result   = s2_q;
  assign z_sh_result = shf(z_sh_data, z_sh_distance, z_sh_direction);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    aclr_n     = 1'b0;
    flush      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    aclr_n = 1'b1;
  endtask

  initial begin
    aclr_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; req0_distance = '0; req1_distance = '0;
    req0_direction = 1'b0; req1_direction = 1'b0; req0_tag = '0; req1_tag = '0;

    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sh_aclr", sh_aclr, 1);
    chk("rst_z_sh_aclr", z_sh_aclr, 1);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    tick();
    req0_valid = 1'b0;
    aclr_n = 1'b1;

    // single right shift, latency PIPELINE+1
    req0_valid = 1'b1; req0_data = 32'h0000_00F0; req0_distance = 5'd4;
    req0_direction = 1'b1; req0_tag = 4'd3;
    #1;
    chk("r23_ready", req0_ready, 1);
    chk("r23_sh_data", sh_data, 32'h0000_00F0);
    chk("r23_sh_aclr", sh_aclr, 0);
    tick();
    req0_valid = 1'b0;
    chk("r23_lat1", out_valid, 0);
    tick();
    chk("r23_lat2", out_valid, 0);
    tick();
    chk("r23_valid", out_valid, 1);
    chk("r23_result", out_result, 32'h0000_000F);
    chk("r23_tag", out_tag, 3);
    chk("r23_port", out_port, 0);
    chk("r23_busy", busy, 1);
    tick();
    chk("r23_drained", out_valid, 0);
    chk("r23_idle", busy, 0);

    // round-robin with both ports valid from reset
    do_reset();
    req0_data = 32'h10; req0_distance = 5'd1; req0_direction = 1'b0;
    req1_data = 32'h80; req1_distance = 5'd3; req1_direction = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_valid = (i < 4);
      req1_valid = (i < 4);
      req0_tag = 4'(i);
      req1_tag = 4'(8 + i);
      #1;
      chk("r24_ready0", req0_ready, (i < 4) && (i % 2 == 0));
      chk("r24_ready1", req1_ready, (i < 4) && (i % 2 == 1));
      tick();
      if (i >= 2) begin
        chk("r24_valid", out_valid, 1);
        chk("r24_tag", out_tag, ((i - 2) % 2 == 1) ? (8 + i - 2) : (i - 2));
        chk("r24_port", out_port, (i - 2) % 2);
        chk("r24_result", out_result, ((i - 2) % 2 == 1) ? 32'h10 : 32'h20);
      end else begin
        chk("r24_early", out_valid, 0);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("r24_drained", out_valid, 0);
    chk("r24_idle", busy, 0);

    // backpressure: 3 stalled cycles after first result
    begin
      int nxt;
      int et;
      nxt = 0;
      for (int c = 0; c <= 10; c++) begin
        out_ready = !(c >= 3 && c <= 5);
        req0_valid = (nxt < 4);
        req0_data = 32'hA5; req0_distance = 5'(nxt); req0_direction = 1'b0;
        req0_tag = 4'(nxt + 1);
        #1;
        chk("r25_ready0", req0_ready, (c <= 2) || (c == 6));
        chk("r25_ready1", req1_ready, 0);
        chk("r25_clken", sh_clken, !(c >= 3 && c <= 5));
        chk("r25_valid", out_valid, (c >= 3 && c <= 9));
        if (c >= 3 && c <= 9) begin
          et = (c <= 6) ? 1 : c - 5;
          chk("r25_tag", out_tag, et);
          chk("r25_result", out_result, 32'hA5 << (et - 1));
        end
        if ((c <= 2) || (c == 6)) nxt++;
        tick();
      end
      req0_valid = 1'b0;
      out_ready = 1'b1;
    end

    // flush with two ops in flight and a held result
    for (int c = 0; c < 3; c++) begin
      req0_valid = 1'b1; req0_data = 32'hA5; req0_distance = 5'd0;
      req0_direction = 1'b0; req0_tag = 4'(c + 1);
      #1;
      chk("r26_issue", req0_ready, 1);
      tick();
    end
    req0_valid = 1'b0;
    chk("r26_pre_valid", out_valid, 1);
    chk("r26_pre_busy", busy, 1);
    flush = 1'b1;
    req1_valid = 1'b1; req1_data = 32'h80; req1_distance = 5'd3;
    req1_direction = 1'b1; req1_tag = 4'd9;
    #1;
    chk("r26_suppress", req1_ready, 0);
    tick();
    flush = 1'b0; req1_valid = 1'b0;
    chk("r26_valid", out_valid, 0);
    chk("r26_busy", busy, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("r26_no_stale", out_valid, 0);
    end
    req0_valid = 1'b1; req0_tag = 4'd2;
    req1_valid = 1'b1; req1_tag = 4'hC;
    #1;
    chk("r26_ptr_r1", req1_ready, 1);
    chk("r26_ptr_r0", req0_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("r26_lat1", out_valid, 0);
    tick();
    chk("r26_lat2", out_valid, 0);
    tick();
    chk("r26_valid2", out_valid, 1);
    chk("r26_tag2", out_tag, 4'hC);
    chk("r26_port2", out_port, 1);
    chk("r26_result2", out_result, 32'h10);
    tick();
    chk("r26_drained", out_valid, 0);

    // asynchronous reset mid-stream
    for (int c = 0; c < 3; c++) begin
      req0_valid = 1'b1; req0_data = 32'h3; req0_distance = 5'd2;
      req0_direction = 1'b0; req0_tag = 4'(c + 1);
      tick();
    end
    req0_tag = 4'd6;
    chk("r27_pre_valid", out_valid, 1);
    aclr_n = 1'b0;
    #1;
    chk("r27_valid", out_valid, 0);
    chk("r27_busy", busy, 0);
    chk("r27_sh_aclr", sh_aclr, 1);
    chk("r27_ready", req0_ready, 0);
    chk("r27_tag", out_tag, 0);
    chk("r27_result", out_result, 0);
    tick();
    chk("r27_held", out_valid, 0);
    aclr_n = 1'b1;
    req0_data = 32'hF0; req0_distance = 5'd4; req0_direction = 1'b1; req0_tag = 4'd7;
    #1;
    chk("r27_post_ready", req0_ready, 1);
    chk("r27_post_aclr", sh_aclr, 0);
    tick();
    req0_valid = 1'b0;
    chk("r27_lat1", out_valid, 0);
    tick();
    chk("r27_lat2", out_valid, 0);
    tick();
    chk("r27_out_valid", out_valid, 1);
    chk("r27_out_tag", out_tag, 7);
    chk("r27_out_result", out_result, 32'h0000_000F);
    tick();
    chk("r27_drained", out_valid, 0);

    // PIPELINE=0 instance: left shift of 1 by 31
    do_reset();
    req0_valid = 1'b1; req0_data = 32'h1; req0_distance = 5'd31;
    req0_direction = 1'b0; req0_tag = 4'd5;
    #1;
    chk("r28_ready0", z_req0_ready, 1);
    chk("r28_ready1", z_req1_ready, 0);
    chk("r28_clken", z_sh_clken, 1);
    tick();
    req0_valid = 1'b0;
    chk("r28_valid", z_out_valid, 1);
    chk("r28_result", z_out_result, 32'h8000_0000);
    chk("r28_tag", z_out_tag, 5);
    chk("r28_port", z_out_port, 0);
    chk("r28_busy", z_busy, 1);
    tick();
    chk("r28_drained", z_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
